// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared CPU defines for the multiply/divide unit
package muldiv_unit_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] ZERO = '0;
   localparam logic RST_ACTIVE = 1'b0;
   localparam int OP_DIV_BIT = 1;
   localparam int OP_UNS_BIT = 0;
   localparam logic [1:0] OP_MULS = 2'b00;
   localparam logic [1:0] OP_MULU = 2'b01;
   localparam logic [1:0] OP_DIVS = 2'b10;
   localparam logic [1:0] OP_DIVU = 2'b11;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;
endpackage

// File: rtl/div_core.sv
// div_core: iterative restoring radix-2 divider on unsigned magnitudes
module div_core
   import muldiv_unit_pkg::*;
#(
   parameter int ITERS = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            last
);
   logic [XLEN-1:0] q_q, r_q, d_q;
   logic [4:0]      cnt_q;
   logic [XLEN:0]   sh, diff;

   assign sh        = {r_q, q_q[XLEN-1]};
   assign diff      = sh - {1'b0, d_q};
   assign quotient  = q_q;
   assign remainder = r_q;
   assign last      = cnt_q == 5'(ITERS - 1);

   // load magnitudes, then shift in one quotient bit per step, restoring on borrow
   always_ff @(posedge clk or negedge resetn) begin
      if (resetn == RST_ACTIVE) begin
         q_q   <= ZERO;
         r_q   <= ZERO;
         d_q   <= ZERO;
         cnt_q <= '0;
      end else if (load) begin
         q_q   <= dividend;
         r_q   <= ZERO;
         d_q   <= divisor;
         cnt_q <= '0;
      end else if (step) begin
         q_q   <= {q_q[XLEN-2:0], ~diff[XLEN]};
         r_q   <= diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
         cnt_q <= cnt_q + 5'd1;
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with sign handling and control FSM
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        w_en_hi,
   output logic        w_en_lo,
   output logic [31:0] data_hi,
   output logic [31:0] data_lo
);
   state_e            state_q, state_d;
   logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q, hi_q, lo_q;
   logic [XLEN-1:0]   a_mag, b_mag, core_q, core_r;
   logic [1:0]        op_q;
   logic [2*XLEN-1:0] ext_a, ext_b, prod, cur;
   logic              accept, div_zero, core_last, sgn_q, neg_quo, neg_rem, strobe;

   assign accept   = state_q == S_IDLE && start && !flush;
   assign div_zero = src_b == ZERO;
   assign a_mag    = (!op[OP_UNS_BIT] && src_a[XLEN-1]) ? -src_a : src_a;
   assign b_mag    = (!op[OP_UNS_BIT] && src_b[XLEN-1]) ? -src_b : src_b;
   assign sgn_q    = !op_q[OP_UNS_BIT];
   assign neg_quo  = sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
   assign neg_rem  = sgn_q && a_q[XLEN-1];
   assign ext_a    = {sgn_q ? {XLEN{a_q[XLEN-1]}} : ZERO, a_q};
   assign ext_b    = {sgn_q ? {XLEN{b_q[XLEN-1]}} : ZERO, b_q};
   assign prod     = ext_a * ext_b;

   div_core #(.ITERS(DIV_ITERS)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .load      (accept && op[OP_DIV_BIT] && !div_zero),
      .step      (state_q == S_DIV),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (core_q),
      .remainder (core_r),
      .last      (core_last)
   );

   // next state plus strobes; flush cancels the operation and masks its strobe
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = !op[OP_DIV_BIT] ? S_MUL : div_zero ? S_DONE : S_DIV;
         S_DIV:  if (core_last) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (flush && state_q != S_IDLE) state_d = S_IDLE;
      busy    = state_q != S_IDLE;
      strobe  = !flush && (state_q == S_MUL || state_q == S_DONE);
      cur     = state_q == S_MUL ? prod : {rem_q, quo_q};
      w_en_hi = strobe;
      w_en_lo = strobe;
      data_hi = strobe ? cur[2*XLEN-1:XLEN] : hi_q;
      data_lo = strobe ? cur[XLEN-1:0] : lo_q;
   end

   // state, operands, signed division result and the last written result
   always_ff @(posedge clk or negedge resetn) begin
      if (resetn == RST_ACTIVE) begin
         state_q <= S_IDLE;
         a_q     <= ZERO;
         b_q     <= ZERO;
         op_q    <= OP_MULS;
         quo_q   <= ZERO;
         rem_q   <= ZERO;
         hi_q    <= ZERO;
         lo_q    <= ZERO;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q  <= src_a;
            b_q  <= src_b;
            op_q <= op;
         end
         if (accept && op[OP_DIV_BIT] && div_zero) begin
            quo_q <= '1;
            rem_q <= src_a;
         end else if (state_q == S_FIX) begin
            quo_q <= neg_quo ? -core_q : core_q;
            rem_q <= neg_rem ? -core_r : core_r;
         end
         if (strobe) begin
            hi_q <= data_hi;
            lo_q <= data_lo;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic        busy, w_en_hi, w_en_lo;
   logic [31:0] data_hi, data_lo;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   muldiv_unit #(.DIV_ITERS(32)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .flush   (flush),
      .busy    (busy),
      .w_en_hi (w_en_hi),
      .w_en_lo (w_en_lo),
      .data_hi (data_hi),
      .data_lo (data_lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every strobe must match the oldest expected result, in time
   always @(negedge clk) begin
      if (w_en_hi || w_en_lo) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got hi=%h lo=%h with no operation pending (cycle %0d)", data_hi, data_lo, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("w_en_hi", 32'(w_en_hi), 32'd1);
            chk("w_en_lo", 32'(w_en_lo), 32'd1);
            chk("data_hi", data_hi, e.hi);
            chk("data_lo", data_lo, e.lo);
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat);
      int nb;
      nb = 0;
      @(negedge clk);
      start = 1'b1;
      op = o;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1 start = 1'b0;
      sb.push_back('{hi: hi, lo: lo, cyc: cyc + lat - 1});
      for (int i = 0; i < lat + 3; i++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      chk("busy_cycles", 32'(nb), 32'(lat));
      chk("drained", 32'(sb.size()), 32'd0);
      chk("hold_hi", data_hi, hi);
      chk("hold_lo", data_lo, lo);
   endtask

   initial begin
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_en", 32'({w_en_hi, w_en_lo}), 32'd0);
      chk("rst_hi", data_hi, 32'h0);
      chk("rst_lo", data_lo, 32'h0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      // multiplies
      issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
      issue(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1);
      issue(2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1);
      issue(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1);
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1);
      // divides: hi = remainder, lo = quotient
      issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34);
      issue(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 34);
      issue(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34);
      issue(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 34);
      issue(2'b11, 32'd5, 32'd9, 32'd5, 32'd0, 34);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
      // divide by zero
      issue(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1);
      issue(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
      // flush in the 10th DIV cycle, then a multiply
      @(negedge clk);
      start = 1'b1;
      op = 2'b11;
      src_a = 32'd1000;
      src_b = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_div_busy", 32'(busy), 32'd0);
      chk("flush_hold_lo", data_lo, 32'hFFFFFFFF);
      issue(2'b00, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1);
      // flush during MUL masks the strobe
      @(negedge clk);
      start = 1'b1;
      op = 2'b01;
      src_a = 32'd9;
      src_b = 32'd9;
      @(posedge clk);
      #1 start = 1'b0;
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_mul_busy", 32'(busy), 32'd0);
      chk("flush_mul_hold", data_lo, 32'h0000000F);
      // start pulsed while busy is ignored
      fork
         issue(2'b11, 32'd77, 32'd10, 32'd7, 32'd7, 34);
         begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            op = 2'b01;
            src_a = 32'd2;
            src_b = 32'd3;
            repeat (3) @(negedge clk);
            start = 1'b0;
         end
      join
      // reset mid-DIV
      @(negedge clk);
      start = 1'b1;
      op = 2'b11;
      src_a = 32'd50;
      src_b = 32'd5;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_en", 32'({w_en_hi, w_en_lo}), 32'd0);
      chk("midrst_hi", data_hi, 32'h0);
      chk("midrst_lo", data_lo, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      chk("postrst_idle", 32'(busy), 32'd0);
      issue(2'b00, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1);
      chk("final_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, %0d compared so far", n_cmp);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DIV_ITERS, default 32, number of radix-2 divide iterations (fixed at 32 for the 32-bit datapath).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  op[1]=1 divide / 0 multiply; op[0]=1 unsigned / 0 signed.
REQ-006 SHALL have ports src_a, src_b  input  32 each  multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have port flush  input  1  exception cancel of the in-flight operation.
REQ-008 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have ports w_en_hi, w_en_lo  output  1 each  one-cycle write strobes to the HI/LO register file.
REQ-010 SHALL have ports data_hi, data_lo  output  32 each  result data for those strobes.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-012 In IDLE with start=1 and flush=0, operands and op SHALL be captured on the edge; with flush=1, start SHALL be ignored.
REQ-013 Multiply: IDLE->MUL->IDLE; the 64-bit product SHALL be formed in MUL, with w_en_hi=w_en_lo=1 during MUL, data_hi=product[63:32], data_lo=product[31:0].
REQ-014 Signed multiply SHALL sign-extend both operands; unsigned SHALL zero-extend.
REQ-015 Divide: IDLE->DIV (exactly DIV_ITERS cycles, one quotient bit per cycle, restoring algorithm on magnitudes)->FIX->DONE->IDLE.
REQ-016 FIX SHALL negate the quotient when signed and operand signs differ, and negate the remainder when signed and the dividend is negative.
REQ-017 DONE SHALL assert both strobes with data_lo=quotient, data_hi=remainder.
REQ-018 Divisor zero SHALL bypass DIV/FIX: IDLE->DONE with data_lo=32'hFFFFFFFF, data_hi=src_a.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield data_lo=0x80000000, data_hi=0 with no special casing.
REQ-020 start SHALL be ignored while busy=1; no queuing.
REQ-021 flush in any non-IDLE state SHALL force IDLE on the next edge, and SHALL combinationally suppress both strobes in that cycle.
REQ-022 Strobes SHALL be high for exactly one cycle per accepted, unflushed operation, always both together.
REQ-023 data_hi/data_lo SHALL hold the last result when strobes are low.
REQ-024 Latency from the start edge: multiply strobe in cycle 1; divide strobe in cycle DIV_ITERS+2; divide-by-zero strobe in cycle 1.

Reset
REQ-025 resetn=0 SHALL asynchronously force IDLE, busy=0, w_en_hi=w_en_lo=0, data_hi=data_lo=0, and clear the iteration counter and operand registers.
REQ-026 Reset mid-operation SHALL discard the operation without a strobe; the first start after release SHALL be accepted normally.

Structure
REQ-027 Data-bus width, zero constant, reset-active level, op encodings, and state encodings SHALL live in the shared CPU defines header.
REQ-028 The iterative magnitude divider (shift/subtract datapath plus 5-bit counter) SHALL be a sub-module div_core; sign handling and the FSM SHALL stay in muldiv_unit.
REQ-029 Strobe and data outputs SHALL connect directly to the HI/LO register write ports with no intervening logic.

Verification
REQ-030 Signed multiply 0xFFFFFFFF*0x00000002 -> strobes in cycle 1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; unsigned -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 Signed divide 0xFFFFFFF9/0x00000002 -> busy for 34 cycles, strobe in cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Unsigned divide 100/0 -> strobe in cycle 1, lo=0xFFFFFFFF, hi=0x00000064; signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 Flush in the 10th DIV cycle -> no strobe, busy=0 next cycle; a multiply started then completes correctly.
REQ-034 start pulsed while busy -> ignored, single strobe only; resetn low mid-DIV -> all outputs 0 immediately, no strobe afterwards.
